// File: rtl/mem_seq_pkg.sv
// Shared types for the memory bus sequencer: FSM state encoding and the
// full-word byte-enable used by instruction fetch.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DREAD,
      DWRITE,
      RESP_IF,
      RESP_DM
   } mem_seq_state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_bus_sequencer.sv
// Arbitrates one Avalon-style memory port between instruction fetch and the
// load/store path; one transaction in flight, data requests win ties.
module mem_bus_sequencer
   import mem_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   input  logic [3:0]        dm_byteenable,
   output logic [31:0]       dm_rdata,
   output logic              dm_valid,
   output logic              stall,
   output logic              err,
   output logic [ADDR_W-1:0] av_address,
   output logic              av_read,
   output logic              av_write,
   output logic [31:0]       av_writedata,
   output logic [3:0]        av_byteenable,
   input  logic [31:0]       av_readdata,
   input  logic              av_waitrequest
);

   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   mem_seq_state_t   state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             unused_addr_lsbs;

   // The requester picks lanes through byte enables; the low address bits are dropped.
   assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

   assign timeout_hit = TO_EN && av_waitrequest && (wait_cnt == CNT_LAST);
   assign stall       = (if_req | dm_req) & ~(if_valid | dm_valid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         av_read       <= 1'b0;
         av_write      <= 1'b0;
         av_address    <= '0;
         av_writedata  <= '0;
         av_byteenable <= '0;
         if_rdata      <= '0;
         dm_rdata      <= '0;
         if_valid      <= 1'b0;
         dm_valid      <= 1'b0;
         err           <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               // While a valid is still up the held request is the one just served.
               if (!(if_valid | dm_valid)) begin
                  if (dm_req) begin
                     av_address    <= {dm_addr[ADDR_W-1:2], 2'b00};
                     av_writedata  <= dm_wdata;
                     av_byteenable <= dm_byteenable;
                     wait_cnt      <= '0;
                     if (dm_write) begin
                        av_write <= 1'b1;
                        state    <= DWRITE;
                     end else begin
                        av_read <= 1'b1;
                        state   <= DREAD;
                     end
                  end else if (if_req) begin
                     av_address    <= {if_addr[ADDR_W-1:2], 2'b00};
                     av_writedata  <= '0;
                     av_byteenable <= BE_WORD;
                     wait_cnt      <= '0;
                     av_read       <= 1'b1;
                     state         <= FETCH;
                  end
               end
            end
            FETCH, DREAD, DWRITE: begin
               if (!av_waitrequest) begin
                  wait_cnt <= '0;
                  av_read  <= 1'b0;
                  av_write <= 1'b0;
                  if (state == FETCH) begin
                     state <= RESP_IF;
                  end else if (state == DREAD) begin
                     state <= RESP_DM;
                  end else begin
                     dm_valid <= 1'b1;
                     state    <= IDLE;
                  end
               end else if (timeout_hit) begin
                  // Abort: complete the requester with zero data and flag the error.
                  wait_cnt <= '0;
                  av_read  <= 1'b0;
                  av_write <= 1'b0;
                  err      <= 1'b1;
                  state    <= IDLE;
                  if (state == FETCH) begin
                     if_valid <= 1'b1;
                     if_rdata <= '0;
                  end else begin
                     dm_valid <= 1'b1;
                     if (state == DREAD) dm_rdata <= '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP_IF: begin
               if_rdata <= av_readdata;
               if_valid <= 1'b1;
               state    <= IDLE;
            end
            RESP_DM: begin
               dm_rdata <= av_readdata;
               dm_valid <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer: per-cycle vector table for fetch,
// waited store and contention, plus hand sequences for timeout and reset.
module tb_mem_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_byteenable;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        stall;
   logic        err;
   logic [31:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic [31:0] av_readdata;
   logic        av_waitrequest;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_bus_sequencer #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_rdata       (if_rdata),
      .if_valid       (if_valid),
      .dm_req         (dm_req),
      .dm_write       (dm_write),
      .dm_addr        (dm_addr),
      .dm_wdata       (dm_wdata),
      .dm_byteenable  (dm_byteenable),
      .dm_rdata       (dm_rdata),
      .dm_valid       (dm_valid),
      .stall          (stall),
      .err            (err),
      .av_address     (av_address),
      .av_read        (av_read),
      .av_write       (av_write),
      .av_writedata   (av_writedata),
      .av_byteenable  (av_byteenable),
      .av_readdata    (av_readdata),
      .av_waitrequest (av_waitrequest)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_write;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [3:0]  dm_be;
      logic        wreq;
      logic [31:0] rdata;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_ifv;
      logic [31:0] e_ifd;
      logic        e_dmv;
      logic [31:0] e_dmd;
      logic        e_err;
      logic        e_stall;
   } vec_t;

   vec_t vec [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_if(input logic req, input logic [31:0] addr);
      if_req  = req;
      if_addr = addr;
   endtask

   initial begin
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; dm_byteenable = '0;
      av_readdata = '0; av_waitrequest = 1'b0;

      // Fetch, no wait
      vec[0]  = '{1'b1, 32'hBFC00003, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24080005,
                  1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
      vec[1]  = '{1'b1, 32'hBFC00003, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24080005,
                  1'b0, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
      vec[2]  = '{1'b1, 32'hBFC00003, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24080005,
                  1'b0, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 1'b1, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b0};
      vec[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 1'b0, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b0};
      // Store with three wait cycles
      for (int i = 4; i <= 7; i++)
         vec[i] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 1'b1, 32'h0,
                    1'b0, 1'b1, 32'h00001004, 4'b0011, 32'hDEADBEEF, 1'b0, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b1};
      vec[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h00001004, 4'b0011, 32'hDEADBEEF, 1'b0, 32'h24080005, 1'b1, 32'h0, 1'b0, 1'b0};
      vec[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h00001004, 4'b0011, 32'hDEADBEEF, 1'b0, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b0};
      // Contention: load first, fetch after the idle gap
      vec[10] = '{1'b1, 32'h00000040, 1'b1, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'hCAFE0001,
                  1'b1, 1'b0, 32'h00002008, 4'hF, 32'h12345678, 1'b0, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b1};
      vec[11] = '{1'b1, 32'h00000040, 1'b1, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'hCAFE0001,
                  1'b0, 1'b0, 32'h00002008, 4'hF, 32'h12345678, 1'b0, 32'h24080005, 1'b0, 32'h0, 1'b0, 1'b1};
      vec[12] = '{1'b1, 32'h00000040, 1'b1, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'hCAFE0001,
                  1'b0, 1'b0, 32'h00002008, 4'hF, 32'h12345678, 1'b0, 32'h24080005, 1'b1, 32'hCAFE0001, 1'b0, 1'b0};
      vec[13] = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'h11112222,
                  1'b0, 1'b0, 32'h00002008, 4'hF, 32'h12345678, 1'b0, 32'h24080005, 1'b0, 32'hCAFE0001, 1'b0, 1'b1};
      vec[14] = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'h11112222,
                  1'b1, 1'b0, 32'h00000040, 4'hF, 32'h0, 1'b0, 32'h24080005, 1'b0, 32'hCAFE0001, 1'b0, 1'b1};
      vec[15] = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'h11112222,
                  1'b0, 1'b0, 32'h00000040, 4'hF, 32'h0, 1'b0, 32'h24080005, 1'b0, 32'hCAFE0001, 1'b0, 1'b1};
      vec[16] = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'h11112222,
                  1'b0, 1'b0, 32'h00000040, 4'hF, 32'h0, 1'b1, 32'h11112222, 1'b0, 32'hCAFE0001, 1'b0, 1'b0};
      vec[17] = '{1'b0, 32'h00000040, 1'b0, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1'b0, 32'h11112222,
                  1'b0, 1'b0, 32'h00000040, 4'hF, 32'h0, 1'b0, 32'h11112222, 1'b0, 32'hCAFE0001, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst av_read", {31'b0, av_read}, 32'h0);
      check("rst av_write", {31'b0, av_write}, 32'h0);
      check("rst av_address", av_address, 32'h0);
      check("rst av_byteenable", {28'b0, av_byteenable}, 32'h0);
      check("rst valids/err", {29'b0, if_valid, dm_valid, err}, 32'h0);
      check("rst rdata", if_rdata | dm_rdata | av_writedata, 32'h0);
      #2 reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         if_req = vec[i].if_req;   if_addr = vec[i].if_addr;
         dm_req = vec[i].dm_req;   dm_write = vec[i].dm_write;
         dm_addr = vec[i].dm_addr; dm_wdata = vec[i].dm_wdata;
         dm_byteenable = vec[i].dm_be;
         av_waitrequest = vec[i].wreq;
         av_readdata = vec[i].rdata;
         step();
         check($sformatf("v%0d av_read", i), {31'b0, av_read}, {31'b0, vec[i].e_rd});
         check($sformatf("v%0d av_write", i), {31'b0, av_write}, {31'b0, vec[i].e_wr});
         check($sformatf("v%0d av_address", i), av_address, vec[i].e_addr);
         check($sformatf("v%0d av_byteenable", i), {28'b0, av_byteenable}, {28'b0, vec[i].e_be});
         check($sformatf("v%0d av_writedata", i), av_writedata, vec[i].e_wd);
         check($sformatf("v%0d if_valid", i), {31'b0, if_valid}, {31'b0, vec[i].e_ifv});
         check($sformatf("v%0d if_rdata", i), if_rdata, vec[i].e_ifd);
         check($sformatf("v%0d dm_valid", i), {31'b0, dm_valid}, {31'b0, vec[i].e_dmv});
         check($sformatf("v%0d dm_rdata", i), dm_rdata, vec[i].e_dmd);
         check($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vec[i].e_err});
         check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vec[i].e_stall});
      end

      // Address changes after grant; seven waits stay below the timeout
      dm_req = 1'b0;
      drive_if(1'b1, 32'h00000104);
      av_waitrequest = 1'b1;
      step();
      check("hold grant av_read", {31'b0, av_read}, 32'h1);
      check("hold grant av_address", av_address, 32'h00000104);
      if_addr = 32'hFFFFFFF0;
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("hold w%0d av_read", k), {31'b0, av_read}, 32'h1);
         check($sformatf("hold w%0d av_address", k), av_address, 32'h00000104);
         check($sformatf("hold w%0d err", k), {31'b0, err}, 32'h0);
      end
      av_waitrequest = 1'b0;
      step();
      check("hold accept av_read", {31'b0, av_read}, 32'h0);
      check("hold accept err", {31'b0, err}, 32'h0);
      av_readdata = 32'h5A5A5A5A;
      step();
      check("hold if_valid", {31'b0, if_valid}, 32'h1);
      check("hold if_rdata", if_rdata, 32'h5A5A5A5A);
      drive_if(1'b0, 32'h0);
      step();

      // Timeout after eight waitrequest cycles
      drive_if(1'b1, 32'h00000200);
      av_waitrequest = 1'b1;
      step();
      check("to grant av_read", {31'b0, av_read}, 32'h1);
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("to w%0d av_read", k), {31'b0, av_read}, 32'h1);
         check($sformatf("to w%0d err/if_valid", k), {30'b0, err, if_valid}, 32'h0);
      end
      step();
      check("to abort av_read", {31'b0, av_read}, 32'h0);
      check("to abort err", {31'b0, err}, 32'h1);
      check("to abort if_valid", {31'b0, if_valid}, 32'h1);
      check("to abort if_rdata", if_rdata, 32'h0);
      check("to abort stall", {31'b0, stall}, 32'h0);
      drive_if(1'b0, 32'h0);
      av_waitrequest = 1'b0;
      step();
      check("to after err/if_valid", {30'b0, err, if_valid}, 32'h0);

      // Asynchronous reset in the middle of a waited fetch
      drive_if(1'b1, 32'h00000300);
      av_waitrequest = 1'b1;
      step();
      step();
      check("rmid pre av_read", {31'b0, av_read}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("rmid av_read", {31'b0, av_read}, 32'h0);
      check("rmid av_address", av_address, 32'h0);
      check("rmid av_byteenable", {28'b0, av_byteenable}, 32'h0);
      check("rmid rdata", if_rdata | dm_rdata, 32'h0);
      check("rmid stall", {31'b0, stall}, 32'h1);
      step();
      #2 reset = 1'b1;
      av_waitrequest = 1'b0;
      av_readdata = 32'h0BADF00D;
      step();
      check("rmid regrant av_read", {31'b0, av_read}, 32'h1);
      check("rmid regrant av_address", av_address, 32'h00000300);
      step();
      check("rmid accept av_read", {31'b0, av_read}, 32'h0);
      step();
      check("rmid if_valid", {31'b0, if_valid}, 32'h1);
      check("rmid if_rdata", if_rdata, 32'h0BADF00D);
      drive_if(1'b0, 32'h0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_sequencer.md
# mem_bus_sequencer

Sequences and arbitrates the CPU's single Avalon-style memory port between the instruction-fetch path and the load/store data path. Each request is latched at grant. The block drives the bus read/write handshake, honouring `waitrequest`, and returns read data with a one-cycle valid pulse. It asserts `stall` toward the pipeline while any request is outstanding. It sits between the datapath (PC / load-store unit driven by the main decoder) and the top-level memory interface.

## Interface
- `TIMEOUT_CYCLES`, 0, max consecutive `waitrequest` cycles before abort; 0 disables the timeout.
- `ADDR_W`, 32, address width.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_rdata` out 32: fetched word; registered.
- `if_valid` out 1: one-cycle pulse; `if_rdata` is valid.
- `dm_req` in 1: data request; held until `dm_valid`.
- `dm_write` in 1: 1 = store, 0 = load.
- `dm_addr` in ADDR_W: data byte address.
- `dm_wdata` in 32: store data.
- `dm_byteenable` in 4: byte lanes for loads and stores.
- `dm_rdata` out 32: load word; registered.
- `dm_valid` out 1: one-cycle completion pulse for load or store.
- `stall` out 1: high while any request is pending and not yet completed.
- `err` out 1: one-cycle pulse on timeout abort.
- `av_address` out ADDR_W: word-aligned bus address, `{addr[ADDR_W-1:2],2'b00}`.
- `av_read` out 1: bus read strobe.
- `av_write` out 1: bus write strobe.
- `av_writedata` out 32: bus write data.
- `av_byteenable` out 4: bus byte enables.
- `av_readdata` in 32: valid in the cycle after read acceptance.
- `av_waitrequest` in 1: slave not ready; the master holds all bus outputs.

## Operation
- States:
  - IDLE
  - FETCH: `av_read`
  - DREAD: `av_read`
  - DWRITE: `av_write`
  - RESP_IF: capture `av_readdata`
  - RESP_DM: capture `av_readdata`
- IDLE transitions:
  - `dm_req` → DREAD or DWRITE. Data has strict priority over fetch, because it belongs to the older instruction.
  - `if_req` only → FETCH.
  - Neither → stay in IDLE.
- Grant: `addr`, `wdata` and `byteenable` are latched into the bus output registers. Fetch uses byteenable 4'b1111. Requester inputs are ignored until completion.
- FETCH/DREAD with `av_waitrequest`=0 → RESP_IF/RESP_DM, and `av_read` drops.
- DWRITE with `av_waitrequest`=0 → IDLE. `av_write` drops and `dm_valid` pulses in the next cycle.
- RESP_*: latch `av_readdata` into `if_rdata`/`dm_rdata`, pulse the matching valid in the next cycle, then go to IDLE.
- With `av_waitrequest`=1, all `av_*` outputs are held bit-stable.
- Wait counter:
  - Increments each cycle the state is FETCH/DREAD/DWRITE and `av_waitrequest`=1.
  - Clears on acceptance and on every new grant.
  - If `TIMEOUT_CYCLES`≠0 and the count reaches `TIMEOUT_CYCLES`: drop strobes, go to IDLE, pulse `err` together with the matching valid.
  - On abort, read data is 32'h0 and the write is lost.
- `stall` = `(if_req|dm_req) & ~(if_valid|dm_valid)`, combinational from the registered valids.
- `dm_addr[1:0]` is not checked. Lane selection is the requester's job, via `dm_byteenable`.

## Timing
- Reset (asynchronous, mid-transaction included):
  - State → IDLE.
  - All outputs 0: `av_read`, `av_write`, `av_address`, `av_writedata`, `av_byteenable`, `if_rdata`, `dm_rdata`, `if_valid`, `dm_valid`, `err`.
  - Wait counter → 0.
  - Strobes drop immediately; a pending transaction is discarded.
- Read latency, zero wait: `req` sampled at E0; `av_read` high in E0–E1; `av_readdata` sampled at E2; valid high in E2–E3. Total 3 cycles; each `waitrequest` cycle adds 1.
- Write latency, zero wait: `dm_valid` after 2 cycles.
- One IDLE cycle always separates consecutive transactions. Back-to-back fetches therefore sustain one per 4 cycles.
- Simultaneous `if_req` and `dm_req` in IDLE: data is served first, then fetch. Fetch is not starved, because `dm_req` cannot re-assert until the pipeline advances.
- Valids never overlap; at most one transaction is in flight.

## Structure
- Shared package `mem_seq_pkg`: state enum `mem_seq_state_t` and constant `BE_WORD=4'b1111`.
- Single module; the wait counter stays inline. `$clog2(TIMEOUT_CYCLES+1)` bits, minimum 1.
- No sub-module is warranted.

## Test plan
- Fetch, no wait: `if_req`=1 with `if_addr`=32'hBFC0_0003, `av_waitrequest`=0, `av_readdata`=32'h2408_0005 → `av_address`=32'hBFC0_0000, `av_byteenable`=4'hF, `av_read` high for 1 cycle, `if_valid` pulse on cycle 3 with `if_rdata`=32'h2408_0005.
- Store with 3 wait cycles: `dm_req`/`dm_write`=1, `dm_addr`=32'h0000_1004, `dm_wdata`=32'hDEAD_BEEF, `dm_byteenable`=4'b0011 → `av_write` and all `av_*` stable for 4 cycles, `dm_valid` 1 cycle later, `stall`=1 throughout.
- Contention: `if_req` and `dm_req` (load) asserted in the same cycle → DREAD is issued first and `dm_valid` fires, then FETCH follows after one IDLE cycle; `if_valid` at cycle 7.
- Timeout: `TIMEOUT_CYCLES`=8, `av_waitrequest` held at 1 during a fetch → after 8 wait cycles `av_read` drops, `err` and `if_valid` pulse together with `if_rdata`=0.
- Reset mid-read: `reset` driven low while in FETCH with `waitrequest`=1 → `av_read`=0 without waiting for an edge, all outputs 0. After `reset` is released, a held `if_req` restarts cleanly from IDLE.
- Input changes after grant: `if_addr` is modified while in FETCH → `av_address` keeps the value latched at grant.
